// File: rtl/dcr_dmem_responder.sv
// Single-port data-memory responder for the MEM stage: 256 x 32-bit storage behind a
// three-state request/response handshake, with saturating read/write transaction counters.
module dcr_dmem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  state_e      state;
  logic        cap_write;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic [31:0] mem [256];
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic        mem_we;

  always_comb begin
    cur_word    = mem[cap_addr];
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (cap_be[i]) merged_word[8*i +: 8] = cap_wdata[8*i +: 8];
    end
    mem_we = (state == StAccess) && cap_write;
  end

  // Storage is deliberately not reset; an async reset forces state to idle, so a write
  // pending in ACCESS never reaches the array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_addr] <= merged_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cap_write <= 1'b0;
      cap_addr  <= 8'h00;
      cap_wdata <= 32'h0;
      cap_be    <= 4'h0;
      rsp_rdata <= 32'h0;
      rd_count  <= 16'h0;
      wr_count  <= 16'h0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            state     <= StAccess;
          end
        end
        StAccess: begin
          rsp_rdata <= cap_write ? merged_word : cur_word;
          state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            if (cap_write) begin
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign req_ready = (state == StIdle);
  assign rsp_valid = (state == StResp);
  assign busy      = (state != StIdle);

endmodule

// File: tb/tb_dcr_dmem_responder.sv
// Directed bench for dcr_dmem_responder: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_dcr_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  dcr_dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction from an idle negedge with rsp_ready=1; ends at the negedge after
  // the response handshake.
  task automatic xact(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp, input string tag);
    chk({tag, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_busy_access"}, busy, 1);
    chk({tag, "_rsp_valid_access"}, rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rsp_valid_resp"}, rsp_valid, 1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rsp_valid_done"}, rsp_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b1;

    // Reset state before any clock edge.
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write then read.
    xact(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, "wr10");
    xact(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, "rd10");

    // Byte enables.
    xact(1'b1, 8'h20, 32'h11223344, 4'hF, 32'h11223344, "wr20_init");
    xact(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, "wr20_be5");
    xact(1'b0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd20");
    chk("wr_count_before_be0", wr_count, 16'd3);
    xact(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, "wr20_be0");
    chk("wr_count_after_be0", wr_count, 16'd4);
    chk("rd_count_mid", rd_count, 16'd2);

    xact(1'b1, 8'h30, 32'h0, 4'hF, 32'h0, "wr30_zero");

    // Backpressure with a competing request held on the bus.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h12345678);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_busy", busy, 0);
    chk("bp_wr_count", wr_count, 16'd6);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_accept", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_rdata", rsp_rdata, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rd_count", rd_count, 16'd3);

    // Reset during ACCESS of a write.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h30;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rdata", rsp_rdata, 32'h0);
    chk("mid_busy", busy, 0);
    chk("mid_rd_count", rd_count, 0);
    chk("mid_wr_count", wr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 8'h30, 32'h0, 4'h0, 32'h0, "rd30_after_rst");

    // Counters: 3 reads, 2 writes since reset.
    xact(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, "cnt_rd10");
    xact(1'b0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, "cnt_rd20");
    xact(1'b1, 8'h50, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, "cnt_wr50");
    xact(1'b1, 8'h50, 32'h00005A00, 4'b0010, 32'hA5A55AA5, "cnt_wr50_b1");
    chk("cnt_rd_count", rd_count, 16'd3);
    chk("cnt_wr_count", wr_count, 16'd2);

    // Back-to-back reads: busy pattern 1,1,0 per issue slot.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_busy", busy, (i % 3 != 2) ? 1 : 0);
      if (i % 3 == 1) chk("b2b_rdata", rsp_rdata, 32'hDEADBEEF);
    end
    req_valid = 1'b0;
    chk("b2b_rd_count", rd_count, 16'd6);

    // Saturation: preload the read counter near the top, then read past it.
    force dut.rd_count = 16'hFFFE;
    #1;
    release dut.rd_count;
    xact(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, "sat_rd1");
    chk("sat_rd_count_1", rd_count, 16'hFFFF);
    xact(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, "sat_rd2");
    chk("sat_rd_count_2", rd_count, 16'hFFFF);
    chk("sat_wr_count", wr_count, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
